instr_fetch_unit: RTL and testbench

Producer end of the immediate/shift datapath interface. Fetches one 16-bit instruction word from memory over a request/ready handshake, holds it in the instruction register and presents the IR fields consumed downstream (IR15_12, IR11_8, IR7_0, IR3_0). Maintains the PC: post-increments on each successful fetch and accepts loads from the branch/jump path. Sits between the memory port and the control/datapath of the 16-bit multicycle processor.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_pc_register.sv | 25 ++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, PC defaults,
// timeout length and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

  localparam int          IFU_DATA_W      = 16;
  localparam logic [15:0] IFU_PC_INC      = 16'd2;
  localparam logic [15:0] IFU_RESET_PC    = 16'h0000;
  localparam int          IFU_TIMEOUT_CYC = 15;
  localparam int          IFU_TMO_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter storage: a load takes priority over the post-fetch increment.
module instr_fetch_unit_pc_register #(
  parameter int         W       = 16,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] INC     = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (srst)       pc_reg <= RST_VAL;
    else if (load)  pc_reg <= load_val;
    else if (inc)   pc_reg <= pc_reg + INC;
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: request/ready memory fetch into IR, PC maintenance.
// Optional macro FETCH_TIMEOUT_EN enables the WAIT-state timeout and sticky FetchErr.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                DATA_W   = IFU_DATA_W,
  parameter logic [DATA_W-1:0] PC_INC   = IFU_PC_INC,
  parameter logic [DATA_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              FetchStart,
  input  logic              PCLoad,
  input  logic [DATA_W-1:0] PCIn,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic              Mem_Req,
  input  logic              Mem_Ready,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] IR,
  output logic [3:0]        IR15_12,
  output logic [3:0]        IR11_8,
  output logic [7:0]        IR7_0,
  output logic [3:0]        IR3_0,
  output logic [DATA_W-1:0] PC,
  output logic              IRValid,
  output logic              Busy,
  output logic              FetchErr
);

  fetch_state_e      state_reg, state_next;
  logic [DATA_W-1:0] ir_reg, mem_addr_reg;
  logic              mem_req_reg;
  logic              in_wait, start, done, timeout;

  assign in_wait = (state_reg == ST_WAIT);
  // Both FetchStart and PCLoad are only honoured outside WAIT.
  assign start   = FetchStart && !in_wait;
  assign done    = in_wait && Mem_Ready;

`ifdef FETCH_TIMEOUT_EN
  logic [IFU_TMO_W-1:0] tmo_cnt_reg;
  logic                 fetch_err_reg;

  // Terminal WAIT cycle is the TIMEOUT_CYC-th one; Mem_Ready on it still wins.
  assign timeout = in_wait && !Mem_Ready &&
                   (tmo_cnt_reg == IFU_TMO_W'(IFU_TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      tmo_cnt_reg   <= '0;
      fetch_err_reg <= 1'b0;
    end else begin
      if (start)                     tmo_cnt_reg <= '0;
      else if (in_wait && !Mem_Ready) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      if (timeout) fetch_err_reg <= 1'b1;
    end
  end

  assign FetchErr = fetch_err_reg;
`else
  assign timeout  = 1'b0;
  assign FetchErr = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (FetchStart) state_next = ST_WAIT;
      ST_WAIT: begin
        if (Mem_Ready)    state_next = ST_VALID;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_VALID: state_next = FetchStart ? ST_WAIT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    IRValid = (state_reg == ST_VALID);
    Busy    = in_wait;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ir_reg       <= '0;
      mem_addr_reg <= '0;
      mem_req_reg  <= 1'b0;
    end else begin
      if (start) begin
        mem_req_reg  <= 1'b1;
        mem_addr_reg <= PCLoad ? PCIn : PC;
      end else if (done || timeout) begin
        mem_req_reg  <= 1'b0;
      end
      if (done) ir_reg <= Mem_Data;
    end
  end

  instr_fetch_unit_pc_register #(
    .W       (DATA_W),
    .RST_VAL (RESET_PC),
    .INC     (PC_INC)
  ) u_pc (
    .clk      (CLK),
    .srst     (Reset),
    .load     (PCLoad && !in_wait),
    .inc      (done),
    .load_val (PCIn),
    .pc       (PC)
  );

  assign Mem_Addr = mem_addr_reg;
  assign Mem_Req  = mem_req_reg;
  assign IR       = ir_reg;
  assign IR15_12  = ir_reg[15:12];
  assign IR11_8   = ir_reg[11:8];
  assign IR7_0    = ir_reg[7:0];
  assign IR3_0    = ir_reg[3:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver pushes expected fetch results,
// a negedge monitor pops and compares whenever IRValid is seen.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        FetchStart = 1'b0, PCLoad = 1'b0, Mem_Ready = 1'b0;
  logic [15:0] PCIn = '0, Mem_Data = '0;
  logic [15:0] Mem_Addr, IR, PC;
  logic [3:0]  IR15_12, IR11_8, IR3_0;
  logic [7:0]  IR7_0;
  logic        Mem_Req, IRValid, Busy, FetchErr;

  instr_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .FetchStart(FetchStart), .PCLoad(PCLoad), .PCIn(PCIn),
    .Mem_Addr(Mem_Addr), .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready), .Mem_Data(Mem_Data),
    .IR(IR), .IR15_12(IR15_12), .IR11_8(IR11_8), .IR7_0(IR7_0), .IR3_0(IR3_0),
    .PC(PC), .IRValid(IRValid), .Busy(Busy), .FetchErr(FetchErr)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [15:0] addr; logic [15:0] data; logic [15:0] pc; } exp_t;
  exp_t sb[$];

  int          errors = 0, checks = 0;
  logic [15:0] pc_m = 16'h0000;   // reference PC
  logic [15:0] ir_m = 16'h0000;   // reference IR
  logic [15:0] seen_addr = '0, last_ir = '0, tg, pc_save;
  bit          last_v = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        last_ir = '0;
        last_v  = 0;
      end else if (IRValid) begin
        check("irvalid_single_pulse", {31'd0, last_v}, 0);
        check("mem_req_low_in_valid", {31'd0, Mem_Req}, 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_irvalid: got IR=%h with empty scoreboard at %0t", IR, $time);
        end else begin
          e = sb.pop_front();
          check("ir", IR, e.data);
          check("ir15_12", IR15_12, e.data[15:12]);
          check("ir11_8", IR11_8, e.data[11:8]);
          check("ir7_0", IR7_0, e.data[7:0]);
          check("ir3_0", IR3_0, e.data[3:0]);
          check("pc_after_fetch", PC, e.pc);
          check("fetch_addr", seen_addr, e.addr);
          $display("fetch addr=%h data=%h pc=%h", seen_addr, IR, PC);
        end
        last_ir = IR;
        last_v  = 1;
      end else begin
        check("ir_stable", IR, last_ir);
        last_v = 0;
      end
      if (Mem_Req) seen_addr = Mem_Addr;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One complete fetch; leaves the DUT in VALID.
  task automatic fetch(input bit load, input logic [15:0] target, input int wcyc,
                       input logic [15:0] data);
    exp_t e;
    FetchStart = 1; PCLoad = load; PCIn = target; Mem_Ready = 0;
    if (load) pc_m = target;
    e.addr = pc_m; e.data = data; e.pc = pc_m + 16'd2;
    sb.push_back(e);
    step();
    FetchStart = 0; PCLoad = 0;
    check("busy_in_wait", {31'd0, Busy}, 1);
    check("mem_req_raised", {31'd0, Mem_Req}, 1);
    check("mem_addr", Mem_Addr, e.addr);
    repeat (wcyc) begin
      PCLoad = 1'($urandom_range(0, 1)); PCIn = 16'($urandom);
      FetchStart = 1'($urandom_range(0, 1));
      step();
    end
    check("mem_addr_held", Mem_Addr, e.addr);
    PCLoad = 1'($urandom_range(0, 1)); PCIn = 16'($urandom);
    FetchStart = 1'($urandom_range(0, 1));
    Mem_Ready = 1; Mem_Data = data;
    step();
    Mem_Ready = 0; PCLoad = 0; FetchStart = 0; Mem_Data = 16'($urandom);
    pc_m = e.pc;
    ir_m = data;
  endtask

  // Idle cycles with occasional PC loads and stray Mem_Ready.
  task automatic idle(input int n);
    bit l;
    repeat (n) begin
      l = ($urandom_range(0, 3) == 0);
      PCLoad = l; PCIn = 16'($urandom) & 16'hFFFE;
      Mem_Ready = 1'($urandom_range(0, 1)); Mem_Data = 16'($urandom);
      if (l) pc_m = PCIn;
      step();
    end
    PCLoad = 0; Mem_Ready = 0;
  endtask

  initial begin
    repeat (2) step();
    Reset = 0;
    check("rst_ir", IR, 0);
    check("rst_pc", PC, 16'h0000);
    check("rst_mem_req", {31'd0, Mem_Req}, 0);
    check("rst_mem_addr", Mem_Addr, 0);
    check("rst_irvalid", {31'd0, IRValid}, 0);
    check("rst_busy", {31'd0, Busy}, 0);
    check("rst_fetcherr", {31'd0, FetchErr}, 0);

    fetch(0, 16'h0000, 1, 16'h8181);
    check("t1_pc", PC, 16'h0002);
    fetch(1, 16'h0040, 0, 16'h1234);
    check("t2_pc", PC, 16'h0042);
    fetch(0, 16'h0000, 3, 16'h5A5A);
    fetch(0, 16'h0000, 0, 16'hC3C3);
    check("b2b_pc", PC, 16'h0046);
    idle(2);

    for (int t = 0; t < 150; t++) begin
      tg = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      fetch($urandom_range(0, 2) == 0, tg, $urandom_range(0, 3), 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    fetch(1, 16'hFFFE, 0, 16'h7E57);
    check("wrap_pc", PC, 16'h0000);
    idle(1);

    // Reset during WAIT with Mem_Ready arriving around it
    FetchStart = 1; PCLoad = 0;
    step();
    FetchStart = 0;
    step();
    Reset = 1; Mem_Ready = 1; Mem_Data = 16'hBEEF;
    step();
    Reset = 0;
    check("rstwait_mem_req", {31'd0, Mem_Req}, 0);
    check("rstwait_busy", {31'd0, Busy}, 0);
    step();
    Mem_Ready = 0;
    check("rstwait_ir", IR, 0);
    check("rstwait_pc", PC, 16'h0000);
    check("rstwait_irvalid", {31'd0, IRValid}, 0);
    pc_m = 16'h0000; ir_m = 16'h0000;

    // Stalled fetch: timeout build aborts, default build waits
    fetch(1, 16'h0100, 1, 16'hA5A5);
    step();
    pc_save = pc_m;
    FetchStart = 1;
    step();
    FetchStart = 0;
`ifdef FETCH_TIMEOUT_EN
    repeat (15) begin
      check("tmo_mem_req_high", {31'd0, Mem_Req}, 1);
      step();
    end
    check("tmo_mem_req_dropped", {31'd0, Mem_Req}, 0);
    check("tmo_fetcherr", {31'd0, FetchErr}, 1);
    check("tmo_busy", {31'd0, Busy}, 0);
    check("tmo_ir", IR, ir_m);
    check("tmo_pc", PC, pc_save);
    step();
    check("tmo_no_irvalid", {31'd0, IRValid}, 0);
    check("tmo_fetcherr_sticky", {31'd0, FetchErr}, 1);
`else
    begin
      exp_t e;
      e.addr = pc_save; e.data = 16'h0F0F; e.pc = pc_save + 16'd2;
      sb.push_back(e);
      repeat (20) begin
        check("stall_mem_req_high", {31'd0, Mem_Req}, 1);
        step();
      end
      check("stall_fetcherr", {31'd0, FetchErr}, 0);
      Mem_Ready = 1; Mem_Data = 16'h0F0F;
      step();
      Mem_Ready = 0;
      pc_m = e.pc;
    end
`endif
    idle(2);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
